fix_add_rr_arbiter: RTL

- Shares one saturating signed fixed-point adder between NREQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- A round-robin arbiter picks one requester per cycle. The selected pair is added with saturation to [-2^(DATA-1), 2^(DATA-1)-1].
- The result is held in a single registered output slot, tagged with the requester ID and a saturation flag, with downstream backpressure.
- Sits between the fixed-point arithmetic units and multiple datapath clients (filter taps, accumulators) that previously needed private adders.

---
 rtl/fix_add_rr_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fix_add_rr_arbiter.sv
// Shared saturating signed fixed-point adder behind a round-robin arbiter.
// One registered result slot carries the sum, the requester id and a clip flag.

module fix_add_sat #(
    parameter int DATA = 16
) (
    input  logic [DATA-1:0] a,
    input  logic [DATA-1:0] b,
    output logic [DATA-1:0] sum,
    output logic            clip
);
    localparam logic [DATA-1:0] MAXV = {1'b0, {(DATA-1){1'b1}}};
    localparam logic [DATA-1:0] MINV = {1'b1, {(DATA-1){1'b0}}};

    logic [DATA:0] wide;

    always_comb begin
        wide = {a[DATA-1], a} + {b[DATA-1], b};
        sum  = wide[DATA-1:0];
        clip = 1'b0;
        // The two top bits of the extended sum disagree only on overflow.
        case ({wide[DATA], wide[DATA-1]})
            2'b01: begin sum = MAXV; clip = 1'b1; end
            2'b10: begin sum = MINV; clip = 1'b1; end
            default: ;
        endcase
    end
endmodule

module fix_add_rr_arbiter #(
    parameter int DATA = 16,
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*DATA-1:0] req_a,
    input  logic [NREQ*DATA-1:0] req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [DATA-1:0]      res_data,
    output logic [IDW-1:0]       res_id,
    output logic                 res_sat,
    output logic [CNTW-1:0]      sat_cnt,
    input  logic                 sat_clr
);
    localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST   = IDW'(NREQ - 1);

    logic [IDW-1:0]  ptr, grant;
    logic [IDW:0]    idx;
    logic [NREQ-1:0] gnt_oh;
    logic            found, slot_free, accept;
    logic [DATA-1:0] a_sel, b_sel, sum;
    logic            clip;

    // Scan ptr, ptr+1, ... wrapping at NREQ; first valid requester wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= NREQ_W) idx = idx - NREQ_W;
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                grant = idx[IDW-1:0];
            end
        end
    end

    assign slot_free = ~res_valid | res_ready;
    assign accept    = slot_free & found;

    always_comb begin
        gnt_oh = '0;
        a_sel  = '0;
        b_sel  = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_oh[i] = found && (grant == IDW'(i));
            a_sel = a_sel | (req_a[i*DATA +: DATA] & {DATA{gnt_oh[i]}});
            b_sel = b_sel | (req_b[i*DATA +: DATA] & {DATA{gnt_oh[i]}});
        end
    end

    assign req_ready = accept ? gnt_oh : '0;

    fix_add_sat #(.DATA(DATA)) u_add (
        .a    (a_sel),
        .b    (b_sel),
        .sum  (sum),
        .clip (clip)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            res_sat   <= 1'b0;
            ptr       <= '0;
            sat_cnt   <= '0;
        end else begin
            if (accept) begin
                res_valid <= 1'b1;
                res_data  <= sum;
                res_id    <= grant;
                res_sat   <= clip;
                ptr       <= (grant == LAST) ? '0 : grant + 1'b1;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
            // Clear wins over counting, but a clip in the clearing cycle still counts.
            if (sat_clr)
                sat_cnt <= (accept && clip) ? CNTW'(1) : '0;
            else if (accept && clip && (sat_cnt != {CNTW{1'b1}}))
                sat_cnt <= sat_cnt + 1'b1;
        end
    end
endmodule
